output_port_sched: RTL and testbench

- Command scheduler in front of the 4-pin output port (D0..D3).
- Buffers single-pin write commands {pin, value} in a small FIFO and applies them one at a time.
- Enforces a minimum hold time between successive pin updates so external loads see each level for at least HOLD_CYCLES+1 clocks.
- Sits between the instruction-decode/execute stage (producer) and the physical output pins; owns the D0..D3 level registers.

---
 rtl/output_port_sched.sv | 194 +++++++++++++++++++
 tb/tb_output_port_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_sched.sv
// -----------------------------------------------------------------------------
// output_port_sched
//
// Command scheduler for the 4-pin output port (D0..D3). Single-pin write
// commands {pin, value} from the execute stage are buffered in a small
// circular FIFO. They are applied one at a time. Each pin update is followed
// by a minimum hold time, so external loads see every level for at least
// HOLD_CYCLES+1 clocks.
//
// Parameters:
//   DEPTH        FIFO entries (power of 2, >= 2)
//   HOLD_CYCLES  extra cycles after an update before the next may apply (>= 0)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   cmd_valid  producer offers a command
//   cmd_ready  scheduler accepts (handshake = cmd_valid & cmd_ready at edge)
//   cmd_pin    target pin index 0..3
//   cmd_value  level to drive on the target pin
//   cmd_toggle (OUTPUT_PORT_TOGGLE_EN only) invert the target pin instead
//   flush      synchronous discard of all queued commands
//   D0..D3     registered pin levels
//   busy       FSM not idle or FIFO non-empty
//   level      current FIFO occupancy
//
// Optional feature macro: OUTPUT_PORT_TOGGLE_EN (adds cmd_toggle).
// -----------------------------------------------------------------------------
module output_port_sched #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_pin,
    input  logic                     cmd_value,
`ifdef OUTPUT_PORT_TOGGLE_EN
    input  logic                     cmd_toggle,
`endif
    input  logic                     flush,
    output logic                     D0,
    output logic                     D1,
    output logic                     D2,
    output logic                     D3,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [CNT_W-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

`ifdef OUTPUT_PORT_TOGGLE_EN
    typedef struct packed {
        logic       toggle;
        logic [1:0] pin;
        logic       value;
    } entry_t;
`else
    typedef struct packed {
        logic [1:0] pin;
        logic       value;
    } entry_t;
`endif

    typedef enum logic [1:0] {
        st_idle,
        st_apply,
        st_hold
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic [3:0]        pins;
    entry_t            mem [DEPTH];
    entry_t            entry_in;
    entry_t            head;
    logic              push, pop;
    logic              full;
    logic              apply_level;

    // Level is registered, so a pop edge never frees room for a same-edge push.
    assign full      = (level == LVL_FULL);
    assign cmd_ready = ~full & ~flush & rst_n;
    assign push      = cmd_valid & cmd_ready;
    // A flush on an APPLY edge suppresses both the pop and the pin write.
    assign pop       = (state == st_apply) & ~flush;
    assign head      = mem[rd_ptr];
    assign busy      = (state != st_idle) | (level != '0);

    assign D0 = pins[0];
    assign D1 = pins[1];
    assign D2 = pins[2];
    assign D3 = pins[3];

`ifdef OUTPUT_PORT_TOGGLE_EN
    assign entry_in    = '{toggle: cmd_toggle, pin: cmd_pin, value: cmd_value};
    assign apply_level = head.toggle ? ~pins[head.pin] : head.value;
`else
    assign entry_in    = '{pin: cmd_pin, value: cmd_value};
    assign apply_level = head.value;
`endif

    // Occupancy update; push and pop together cancel out.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            st_idle: begin
                if (level != '0) state_nxt = st_apply;
            end
            st_apply: begin
                if (HOLD_CYCLES > 0) begin
                    state_nxt = st_hold;
                    cnt_nxt   = HOLD_INIT;
                end else begin
                    // Back-to-back only if an already-queued entry remains
                    // behind the one being popped (a same-edge push waits for
                    // IDLE, matching the HOLD exit rule).
                    state_nxt = (level != LVL_ONE) ? st_apply : st_idle;
                end
            end
            st_hold: begin
                if (cnt == '0) begin
                    state_nxt = (level != '0) ? st_apply : st_idle;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = st_idle;
        endcase
        if (flush) begin
            state_nxt = st_idle;
            cnt_nxt   = '0;
        end
    end

    // Control and pin registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state  <= st_idle;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            pins   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr          <= rd_ptr + 1'b1;
                    pins[head.pin]  <= apply_level;
                end
                level <= level_nxt;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; level and the
        // pointers define which entries are valid, so stale data is never read.
        if (push) mem[wr_ptr] <= entry_in;
    end

endmodule

// File: tb/tb_output_port_sched.sv
// -----------------------------------------------------------------------------
// tb_output_port_sched
//
// Self-checking bench for output_port_sched. Each accepted command pushes the
// expected pin vector and its expected update edge onto a scoreboard queue.
// The entry is popped and compared on the edge where the DUT should apply it.
// Pins, level, busy and cmd_ready are compared every cycle.
// -----------------------------------------------------------------------------
module tb_output_port_sched;

    localparam int DEPTH       = 4;
    localparam int HOLD_CYCLES = 3;

    logic                   clk;
    logic                   rst_n;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_pin;
    logic                   cmd_value;
`ifdef OUTPUT_PORT_TOGGLE_EN
    logic                   cmd_toggle;
`endif
    logic                   flush;
    logic                   d0, d1, d2, d3;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;

    output_port_sched #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_pin    (cmd_pin),
        .cmd_value  (cmd_value),
`ifdef OUTPUT_PORT_TOGGLE_EN
        .cmd_toggle (cmd_toggle),
`endif
        .flush      (flush),
        .D0         (d0),
        .D1         (d1),
        .D2         (d2),
        .D3         (d3),
        .busy       (busy),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [3:0] pins;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] shadow;      // pins after every accepted command has applied
    logic [3:0] cur_exp;     // pins expected right now
    int         sched_last;  // edge of the latest scheduled pin update
    int         cyc;
    int         n_vec;
    int         n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at the low phase, check ready, clock, update the
    // scoreboard, then compare outputs on the falling edge.
    task automatic step(input logic v, input logic [1:0] p, input logic val,
                        input logic tg, input logic fl, input logic rn,
                        output logic acc);
        logic exp_rdy;
        int   t;
        exp_t e;
        cmd_valid = v;
        cmd_pin   = p;
        cmd_value = val;
`ifdef OUTPUT_PORT_TOGGLE_EN
        cmd_toggle = tg;
`endif
        flush     = fl;
        rst_n     = rn;
        #1;
        exp_rdy = rn && !fl && (sb.size() < DEPTH);
        check("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_rdy});
        acc = v && exp_rdy;
        @(posedge clk);
        cyc++;
        if (!rn) begin
            sb.delete();
            shadow     = '0;
            cur_exp    = '0;
            sched_last = -1000;
        end else if (fl) begin
            sb.delete();
            shadow     = cur_exp;
            sched_last = -1000;
        end else if (acc) begin
            t = cyc + 2;
            if (sched_last + HOLD_CYCLES + 1 > t) t = sched_last + HOLD_CYCLES + 1;
            shadow[p] = tg ? ~shadow[p] : val;
            sb.push_back('{t: t, pins: shadow});
            sched_last = t;
        end
        @(negedge clk);
        if (sb.size() > 0 && sb[0].t == cyc) begin
            e       = sb.pop_front();
            cur_exp = e.pins;
        end
        check("pins", {28'b0, d3, d2, d1, d0}, {28'b0, cur_exp});
        check("level", 32'(level), 32'(sb.size()));
        check("busy", {31'b0, busy}, {31'b0, (cyc < sched_last + HOLD_CYCLES)});
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic send(input logic [1:0] p, input logic val, input logic tg);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 64) begin
            step(1'b1, p, val, tg, 1'b0, 1'b1, acc);
            n++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() > 0 || cyc < sched_last + HOLD_CYCLES) && n < 200) begin
            idle(1);
            n++;
        end
        idle(1);
    endtask

    initial begin
        logic acc;
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        shadow     = '0;
        cur_exp    = '0;
        sched_last = -1000;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_pin    = '0;
        cmd_value  = 1'b0;
`ifdef OUTPUT_PORT_TOGGLE_EN
        cmd_toggle = 1'b0;
`endif
        flush      = 1'b0;
        @(negedge clk);

        // Reset with cmd_valid held high: nothing accepted, outputs cleared.
        step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        check("rst_level", 32'(level), 32'd0);
        check("rst_pins", {28'b0, d3, d2, d1, d0}, 32'h0);
        idle(1);
        check("rst_release_ready", {31'b0, cmd_ready}, 32'd1);

        // Single write to D2.
        send(2'd2, 1'b1, 1'b0);
        drain();
        check("single_pins", {28'b0, d3, d2, d1, d0}, 32'h4);

        // Back-to-back spacing.
        send(2'd0, 1'b1, 1'b0);
        send(2'd1, 1'b1, 1'b0);
        send(2'd3, 1'b1, 1'b0);
        send(2'd0, 1'b0, 1'b0);
        drain();
        check("spacing_final", {28'b0, d3, d2, d1, d0}, 32'hE);

        // Full boundary: six commands with cmd_valid held through pops.
        send(2'd0, 1'b1, 1'b0);
        send(2'd1, 1'b0, 1'b0);
        send(2'd2, 1'b0, 1'b0);
        send(2'd3, 1'b0, 1'b0);
        send(2'd0, 1'b0, 1'b0);
        send(2'd1, 1'b1, 1'b0);
        drain();
        check("full_final", {28'b0, d3, d2, d1, d0}, 32'h2);

        // Flush on the first APPLY of three queued commands.
        send(2'd3, 1'b1, 1'b0);
        send(2'd0, 1'b1, 1'b0);
        send(2'd1, 1'b0, 1'b0);
        send(2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 40 && sb.size() > 0 && cyc + 1 < sb[0].t; i++) idle(1);
        step(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        idle(2);
        check("flush_level", 32'(level), 32'd0);
        check("flush_pins", {28'b0, d3, d2, d1, d0}, 32'hA);
        check("flush_busy", {31'b0, busy}, 32'd0);

        // Reset mid-operation.
        send(2'd1, 1'b1, 1'b0);
        send(2'd2, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        idle(3);
        check("midrst_pins", {28'b0, d3, d2, d1, d0}, 32'h0);

`ifdef OUTPUT_PORT_TOGGLE_EN
        // Toggle D1 twice; the stored value is ignored.
        send(2'd1, 1'b0, 1'b1);
        drain();
        check("toggle1_d1", {31'b0, d1}, 32'd1);
        send(2'd1, 1'b1, 1'b1);
        drain();
        check("toggle2_d1", {31'b0, d1}, 32'd0);
`endif

        // Random traffic with random gaps.
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
            idle($urandom_range(0, 3));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
